// File: rtl/disp_pkg.sv
// Shared constants, FSM state type and the double-dabble step used by the
// seven-segment scan controller.
package disp_pkg;

  localparam logic [3:0] BLANK_CODE  = 4'hF;
  localparam int         NUM_DIGITS  = 8;
  localparam int         HALF_DIGITS = 4;
  localparam int         BIN_W       = 16;
  localparam int         BCD_W       = 20;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV1  = 2'd1,
    S_CONV2  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  // One shift-add-3 iteration: bias every BCD digit >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] acc,
                                                   input logic             bit_in);
    logic [BCD_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bcd_dabble16.sv
// Sequential 16-bit binary to 20-bit BCD converter: one shift-add-3 step per
// cycle, 16 steps per conversion, the first step taken on the start edge.
module bcd_dabble16
  import disp_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic        done,
  output logic [19:0] bcd
);

  logic [BIN_W-1:0] sr;
  logic [3:0]       steps;
  logic             run;

  // done is high in the cycle whose closing edge performs the 16th step,
  // so bcd holds the finished result immediately after that edge.
  assign done = run && (steps == 4'd15);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sr    <= '0;
      steps <= '0;
      run   <= 1'b0;
      bcd   <= '0;
    end else if (start) begin
      bcd   <= dabble_step('0, din[BIN_W-1]);
      sr    <= {din[BIN_W-2:0], 1'b0};
      steps <= 4'd1;
      run   <= 1'b1;
    end else if (run) begin
      bcd   <= dabble_step(bcd, sr[BIN_W-1]);
      sr    <= {sr[BIN_W-2:0], 1'b0};
      steps <= steps + 4'd1;
      if (steps == 4'd15) run <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Captures two 16-bit values, converts them to BCD with a shared shift-add-3
// engine, commits all eight digits atomically and scans them onto one decoder.
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Number1,
  input  logic [15:0] Number2,
  input  logic        Load,
  output logic        Busy,
  output logic        Overflow1,
  output logic        Overflow2,
  output logic [3:0]  in4,
  output logic [7:0]  en_out
);

  state_t                  state;
  logic                    start_q;
  logic                    pending;
  logic                    conv_done;
  logic [BIN_W-1:0]        shadow1, shadow2, pend1, pend2, conv_din;
  logic [BCD_W-1:0]        bcd1, conv_bcd;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              sel;
  logic [1:0]              pos;
  logic [4*HALF_DIGITS-1:0] half;
  logic                    half_ovf;
  logic                    lead_zero;
  logic [3:0]              raw;
  logic [3:0]              shown;

  assign conv_din = (state == S_CONV2) ? shadow2 : shadow1;

  bcd_dabble16 u_dabble (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start_q),
    .din   (conv_din),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Load is a one-cycle request with no ready: it is always accepted, into the
  // shadow regs when idle and into the single pending slot (last one wins) otherwise.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      Busy      <= 1'b0;
      pending   <= 1'b0;
      shadow1   <= '0;
      shadow2   <= '0;
      pend1     <= '0;
      pend2     <= '0;
      bcd1      <= '0;
      digits    <= '0;
      Overflow1 <= 1'b0;
      Overflow2 <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Load) begin
            shadow1 <= Number1;
            shadow2 <= Number2;
            Busy    <= 1'b1;
            start_q <= 1'b1;
            state   <= S_CONV1;
          end
        end
        S_CONV1: begin
          if (Load) begin
            pend1   <= Number1;
            pend2   <= Number2;
            pending <= 1'b1;
          end
          if (conv_done) begin
            start_q <= 1'b1;
            state   <= S_CONV2;
          end
        end
        S_CONV2: begin
          if (Load) begin
            pend1   <= Number1;
            pend2   <= Number2;
            pending <= 1'b1;
          end
          // The engine still holds the first result until its restart edge.
          if (start_q) bcd1 <= conv_bcd;
          if (conv_done) state <= S_COMMIT;
        end
        S_COMMIT: begin
          digits    <= {conv_bcd[15:0], bcd1[15:0]};
          Overflow1 <= |bcd1[19:16];
          Overflow2 <= |conv_bcd[19:16];
          if (Load) begin
            shadow1 <= Number1;
            shadow2 <= Number2;
            pending <= 1'b0;
            start_q <= 1'b1;
            state   <= S_CONV1;
          end else if (pending) begin
            shadow1 <= pend1;
            shadow2 <= pend2;
            pending <= 1'b0;
            start_q <= 1'b1;
            state   <= S_CONV1;
          end else begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    sel      = cnt[CNT_W-1 -: 3];
    pos      = sel[1:0];
    half     = sel[2] ? digits[31:16] : digits[15:0];
    half_ovf = sel[2] ? Overflow2 : Overflow1;
    raw      = half[{pos, 2'b00} +: 4];
    case (pos)
      2'd1:    lead_zero = (half[15:4] == 12'd0);
      2'd2:    lead_zero = (half[15:8] == 8'd0);
      2'd3:    lead_zero = (half[15:12] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    if (half_ovf || (BLANK_LEADING && lead_zero)) shown = BLANK_CODE;
    else                                          shown = raw;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt    <= '0;
      en_out <= 8'hFF;
      in4    <= BLANK_CODE;
    end else begin
      cnt    <= cnt + 1'b1;
      en_out <= ~(8'b1 << sel);
      in4    <= shown;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed scenarios plus random loads, checked
// every cycle against a transaction-level model of loads, commits and the scan.
module tb_display_scan_controller;

  localparam int CNT_W = 6;
  localparam int LAT   = 33;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic [15:0] n1   = '0;
  logic [15:0] n2   = '0;
  logic        busy, ovf1, ovf2, busy_nb, ovf1_nb, ovf2_nb;
  logic [3:0]  in4, in4_nb;
  logic [7:0]  en_out, en_nb;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  display_scan_controller #(.CNT_W(CNT_W), .BLANK_LEADING(1'b1)) u_dut (
    .Clk(clk), .Rst(rst), .Number1(n1), .Number2(n2), .Load(load),
    .Busy(busy), .Overflow1(ovf1), .Overflow2(ovf2), .in4(in4), .en_out(en_out)
  );

  display_scan_controller #(.CNT_W(CNT_W), .BLANK_LEADING(1'b0)) u_dut_nb (
    .Clk(clk), .Rst(rst), .Number1(n1), .Number2(n2), .Load(load),
    .Busy(busy_nb), .Overflow1(ovf1_nb), .Overflow2(ovf2_nb), .in4(in4_nb), .en_out(en_nb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q[0] is the conversion in flight, exp_q[1] the pending request.
  logic [31:0] exp_q[$];
  int          com1 = 0, com2 = 0;
  int          m_cnt = 0, m_edge = 0, commit_at = 0;
  logic [7:0]  exp_en = 8'hFF;
  logic [3:0]  exp_in4 = 4'hF, exp_in4_nb = 4'hF;

  function automatic logic [3:0] shown_digit(input int p, input bit bl);
    int v, p10;
    v   = (p < 4) ? com1 : com2;
    p10 = 10 ** (p % 4);
    if (v > 9999) return 4'hF;
    if (bl && (p % 4) != 0 && v < p10) return 4'hF;
    return 4'((v / p10) % 10);
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        com1 = 0; com2 = 0; m_cnt = 0; m_edge = 0; commit_at = 0;
        exp_en = 8'hFF; exp_in4 = 4'hF; exp_in4_nb = 4'hF;
      end else begin
        for (int i = 0; i < 8; i++) exp_en[i] = (i != m_cnt / 8);
        exp_in4    = shown_digit(m_cnt / 8, 1'b1);
        exp_in4_nb = shown_digit(m_cnt / 8, 1'b0);
        m_cnt  = (m_cnt + 1) % 64;
        m_edge = m_edge + 1;
        if (exp_q.size() > 0 && m_edge == commit_at) begin
          {com1[15:0], com2[15:0]} = exp_q.pop_front();
          com1[31:16] = '0; com2[31:16] = '0;
          if (load) begin
            if (exp_q.size() > 0) exp_q[0] = {n1, n2};
            else                  exp_q.push_back({n1, n2});
          end
          if (exp_q.size() > 0) commit_at = m_edge + LAT;
        end else if (load) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back({n1, n2});
            commit_at = m_edge + LAT;
          end else if (exp_q.size() == 1) exp_q.push_back({n1, n2});
          else                            exp_q[1] = {n1, n2};
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("busy",    busy,       exp_q.size() > 0);
      chk("ovf1",    ovf1,       com1 > 9999);
      chk("ovf2",    ovf2,       com2 > 9999);
      chk("en_out",  en_out,     exp_en);
      chk("in4",     in4,        exp_in4);
      chk("busy_nb", busy_nb,    exp_q.size() > 0);
      chk("ovf1_nb", ovf1_nb,    com1 > 9999);
      chk("ovf2_nb", ovf2_nb,    com2 > 9999);
      chk("en_nb",   en_nb,      exp_en);
      chk("in4_nb",  in4_nb,     exp_in4_nb);
    end
  end

  // ---------------- driver tasks ----------------
  logic [3:0] cap[8], cap_nb[8];
  int         seen[8];

  task automatic do_load(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    n1 = a; n2 = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n <= 500) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n > 500) chk("idle_timeout", n, 0);
  endtask

  task automatic scan_capture();
    for (int i = 0; i < 8; i++) begin
      cap[i] = 4'h0; cap_nb[i] = 4'h0; seen[i] = 0;
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      chk("onehot", $countones(~en_out), 1);
      for (int i = 0; i < 8; i++) begin
        if (!en_out[i]) begin cap[i] = in4; seen[i]++; end
        if (!en_nb[i]) cap_nb[i] = in4_nb;
      end
    end
  endtask

  function automatic logic [15:0] lo(input bit nb);
    return nb ? {cap_nb[3], cap_nb[2], cap_nb[1], cap_nb[0]} : {cap[3], cap[2], cap[1], cap[0]};
  endfunction

  function automatic logic [15:0] hi(input bit nb);
    return nb ? {cap_nb[7], cap_nb[6], cap_nb[5], cap_nb[4]} : {cap[7], cap[6], cap[5], cap[4]};
  endfunction

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 9));
      1:       return 16'($urandom_range(0, 9999));
      2:       return 16'($urandom_range(9990, 10010));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // reset state, then blanked zero display
    repeat (3) @(negedge clk);
    chk("t1_rst_en", en_out, 8'hFF);
    chk("t1_rst_in4", in4, 4'hF);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    scan_capture();
    chk("t1_lo", lo(0), 16'hFFF0);
    chk("t1_hi", hi(0), 16'hFFF0);
    chk("t1_lo_nb", lo(1), 16'h0000);
    for (int i = 0; i < 8; i++) chk("t6_seen", seen[i], 8);

    // basic conversion and latency
    do_load(16'd1234, 16'd56);
    wait_idle(n);
    chk("t2_busy_len", n, LAT);
    scan_capture();
    chk("t2_lo", lo(0), 16'h1234);
    chk("t2_hi", hi(0), 16'hFF56);
    chk("t2_ovf", {ovf1, ovf2}, 2'b00);

    // overflow in both halves, then recovery in one
    do_load(16'd10000, 16'd65535);
    wait_idle(n);
    scan_capture();
    chk("t3_ovf", {ovf1, ovf2}, 2'b11);
    chk("t3_lo", lo(0), 16'hFFFF);
    chk("t3_hi", hi(0), 16'hFFFF);
    chk("t3_lo_nb", lo(1), 16'hFFFF);
    do_load(16'd9999, 16'd65535);
    wait_idle(n);
    scan_capture();
    chk("t3b_ovf", {ovf1, ovf2}, 2'b01);
    chk("t3b_lo", lo(0), 16'h9999);

    // loads while busy: last pending wins, busy never drops
    do_load(16'd1, 16'd0);
    repeat (9) @(posedge clk);
    #1 n1 = 16'd7; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (9) @(posedge clk);
    #1 n1 = 16'd8; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    wait_idle(n);
    chk("t4_busy_total", 20 + n, 2 * LAT);
    scan_capture();
    chk("t4_lo", lo(0), 16'hFFF8);

    // asynchronous reset mid-conversion
    do_load(16'd4321, 16'd0);
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_en", en_out, 8'hFF);
    chk("t5_in4", in4, 4'hF);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    scan_capture();
    chk("t5_lo", lo(0), 16'hFFF0);
    do_load(16'd5678, 16'd0);
    wait_idle(n);
    chk("t5_busy_len", n, LAT);
    scan_capture();
    chk("t5b_lo", lo(0), 16'h5678);

    // leading-zero blanking on/off
    do_load(16'd500, 16'd0);
    wait_idle(n);
    scan_capture();
    chk("t6_lo", lo(0), 16'hF500);
    chk("t6_lo_nb", lo(1), 16'h0500);
    chk("t6_hi_nb", hi(1), 16'h0000);

    // random loads, including back-to-back and during conversion
    for (int k = 0; k < 60; k++) begin
      do_load(rnd_val(), rnd_val());
      repeat ($urandom_range(0, 45)) @(posedge clk);
    end
    wait_idle(n);
    repeat (70) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
